stamp_step_arbiter: RTL and testbench

// Per-timestep scheduler for the shared matrix-stamp datapath used by the netlist elements (R, C, port,

---
 rtl/stamp_step_arbiter.sv | 127 ++++++++++++
 tb/tb_stamp_step_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stamp_step_arbiter.sv
// rtl/stamp_step_arbiter.sv - per-timestep launch, round-robin stamp bus arbitration and step completion
module stamp_step_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        step_done,
  output logic [15:0]                 step_count,
  output logic [N_REQ-1:0]            eval_go,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*DATA_W-1:0]     req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_done,
  output logic                        m_valid,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_last,
  output logic [$clog2(N_REQ)-1:0]    m_src,
  input  logic                        m_ready,
  output logic                        burst_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_ARB, S_XFER, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [N_REQ-1:0]   done_mask, done_eff, cand;
  logic [CNT_W-1:0]   beat_cnt;
  logic               found;
  logic [IDX_W-1:0]   pick;
  logic               accept, forced;

  assign done_eff = done_mask | req_done;
  assign cand     = req_valid & ~done_eff;

  // Scan starting at the round-robin pointer; first live candidate wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && cand[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        pick  = IDX_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    step_done = 1'b0;
    eval_go   = '0;
    req_ready = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_last    = 1'b0;
    accept    = 1'b0;
    forced    = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        eval_go   = '1;
        state_nxt = S_ARB;
      end
      S_ARB: begin
        if (&done_eff)  state_nxt = S_DONE;
        else if (found) state_nxt = S_XFER;
      end
      S_XFER: begin
        m_valid          = req_valid[m_src];
        m_data           = req_data[int'(m_src)*DATA_W +: DATA_W];
        m_last           = req_last[m_src] | (beat_cnt == CNT_W'(MAX_BEATS - 1));
        req_ready[m_src] = m_ready;
        accept           = m_valid & m_ready;
        forced           = accept & m_last & ~req_last[m_src];
        if (accept && m_last) state_nxt = S_ARB;
      end
      S_DONE: begin
        step_done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      m_src      <= '0;
      done_mask  <= '0;
      beat_cnt   <= '0;
      burst_err  <= 1'b0;
      step_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_LAUNCH: done_mask <= '0;
        S_ARB: begin
          done_mask <= done_eff;
          if (!(&done_eff) && found) begin
            m_src    <= pick;
            beat_cnt <= '0;
          end
        end
        S_XFER: begin
          done_mask <= done_eff;
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (m_last) ptr <= (m_src == IDX_W'(N_REQ - 1)) ? '0 : m_src + IDX_W'(1);
          end
          if (forced) burst_err <= 1'b1;
        end
        S_DONE: step_count <= step_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stamp_step_arbiter.sv
// tb/tb_stamp_step_arbiter.sv - randomized directed bench with queue-based scheduling reference model
module tb_stamp_step_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 16;

  logic           clk = 1'b0;
  logic           rst, start, busy, step_done, m_valid, m_last, m_ready, burst_err;
  logic [15:0]    step_count;
  logic [N-1:0]   eval_go, req_valid, req_last, req_ready, req_done;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   m_data;
  logic [1:0]     m_src;

  always #5 clk = ~clk;

  stamp_step_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .step_done(step_done),
    .step_count(step_count), .eval_go(eval_go), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .req_done(req_done), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_src(m_src), .m_ready(m_ready), .burst_err(burst_err)
  );

  typedef struct {logic [W-1:0] d; bit last;} beat_t;
  typedef struct {int src; logic [W-1:0] d; bit last;} xfer_t;

  beat_t rq[N][$];
  xfer_t exp_q[$];
  bit    in_burst[N];
  int    model_ptr, model_cnt, mode, tests, fails;
  bit    exp_err, drop_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_burst(input int i, input int len, input int last_at);
    for (int b = 1; b <= len; b++) rq[i].push_back('{$urandom, b == last_at});
  endtask

  // Reference: serve pending bursts round-robin, capping each burst at MB beats.
  task automatic build_expected();
    int pos[N];
    int left, i, cnt;
    bit lst;
    beat_t b;
    for (int k = 0; k < N; k++) pos[k] = 0;
    while (1) begin
      left = 0;
      for (int k = 0; k < N; k++) left += rq[k].size() - pos[k];
      if (left == 0) break;
      i = model_ptr;
      while (pos[i] >= rq[i].size()) i = (i + 1) % N;
      cnt = 0;
      lst = 0;
      while (!lst && pos[i] < rq[i].size()) begin
        b = rq[i][pos[i]];
        pos[i]++;
        cnt++;
        lst = b.last || (cnt == MB);
        if (cnt == MB && !b.last) exp_err = 1;
        exp_q.push_back('{i, b.d, lst});
      end
      model_ptr = (i + 1) % N;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]       = !(drop_en && in_burst[i] && $urandom_range(0, 2) == 0);
        req_data[i*W +: W] = rq[i][0].d;
        req_last[i]        = rq[i][0].last;
        req_done[i]        = 1'b0;
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*W +: W] = '0;
        req_last[i]        = 1'b0;
        req_done[i]        = 1'b1;
      end
    end
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic cycle(input int c, input bit stepck, output bit sd);
    logic [N-1:0] acc, oh;
    xfer_t e;
    drive();
    #1;
    if (stepck) begin
      chk("eval_go", 32'(eval_go), (c == 0) ? 32'hF : 32'h0);
      chk("busy", 32'(busy), 32'd1);
    end
    sd = step_done;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) e = '{-1, '0, 1'b0};
      else e = exp_q.pop_front();
      oh = '0;
      oh[m_src] = 1'b1;
      chk("beat_src", 32'(m_src), 32'(e.src));
      chk("beat_data", m_data, e.d);
      chk("beat_last", 32'(m_last), 32'(e.last));
      chk("req_ready_grant", 32'(req_ready), 32'(oh));
      in_burst[m_src] = !m_last;
    end else if (!m_ready) begin
      chk("req_ready_stall", 32'(req_ready), 32'd0);
    end
    acc = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
  endtask

  task automatic pulse_start();
    drive();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_step(input int mode_i, input bit drop_i, input int want_done);
    bit sd, seen;
    int done_c;
    mode    = mode_i;
    drop_en = drop_i;
    build_expected();
    pulse_start();
    seen   = 0;
    done_c = -1;
    for (int c = 0; c < 3000 && !seen; c++) begin
      cycle(c, 1'b1, sd);
      if (sd) begin
        seen   = 1;
        done_c = c;
      end
    end
    chk("step_done_seen", 32'(seen), 32'd1);
    if (want_done >= 0) chk("step_done_cycle", 32'(done_c), 32'(want_done));
    model_cnt = (model_cnt + 1) & 16'hFFFF;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_step_done", 32'(step_done), 32'd0);
    chk("step_count", 32'(step_count), 32'(model_cnt));
    chk("burst_err", 32'(burst_err), 32'(exp_err));
    chk("beats_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      in_burst[i] = 0;
    end
    exp_q.delete();
    model_ptr = 0;
    model_cnt = 0;
    exp_err   = 0;
  endtask

  initial begin
    bit sd;
    int c, nb;
    tests = 0;
    fails = 0;
    mode = 0;
    drop_en = 0;
    clear_model();
    rst = 1'b1;
    start = 1'b0;
    m_ready = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_done = '0;
    req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_step_done", 32'(step_done), 32'd0);
    chk("rst_eval_go", 32'(eval_go), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_src", 32'(m_src), 32'd0);
    chk("rst_burst_err", 32'(burst_err), 32'd0);
    chk("rst_step_count", 32'(step_count), 32'd0);

    // Reset in the middle of a burst, two beats in.
    add_burst(1, 5, 5);
    build_expected();
    mode = 0;
    pulse_start();
    c = 0;
    while (exp_q.size() > 3 && c < 100) begin
      cycle(c, 1'b1, sd);
      c++;
    end
    chk("midrst_beats_before", 32'(exp_q.size()), 32'd3);
    rst = 1'b1;
    drive();
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_step_count", 32'(step_count), 32'd0);
    rst = 1'b0;
    clear_model();

    // Clean step with every evaluator already done.
    run_step(0, 0, 2);

    add_burst(0, 3, 3);
    add_burst(2, 3, 3);
    run_step(0, 0, -1);

    for (int i = 0; i < N; i++) begin
      add_burst(i, 1, 1);
      add_burst(i, 1, 1);
    end
    run_step(0, 0, -1);

    add_burst(1, 20, 20);
    run_step(0, 0, -1);

    add_burst(2, 4, 4);
    run_step(1, 0, -1);

    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < N; i++) begin
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) begin
          int len;
          len = $urandom_range(1, 6);
          add_burst(i, len, len);
        end
      end
      run_step(2, 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
